// File: rtl/clk_div_ratio_meter.sv
// Measures the period (divide ratio) of an asynchronous divided clock in clk cycles, with lock and
// loss-of-signal detection. Optional high-time measurement is built when DUTY_MEAS_EN is defined.
module clk_div_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MAX       = '1;
    localparam int               MW        = $clog2(LOCK_CNT);
    localparam logic [MW-1:0]    MATCH_TOP = MW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, p, rise;
    logic [CNT_W-1:0]       cnt;
    logic [MW-1:0]          match, match_nxt;
    logic                   have_prev;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~p;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            p    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            p    <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise) state_nxt = MEAS;
                MEAS:    if (!rise && cnt == MAX) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // period still holds the value from before ARM, so have_prev gates the first comparison
    always_comb begin
        match_nxt = '0;
        if (have_prev && cnt == period)
            match_nxt = (match == MATCH_TOP) ? match : match + MW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            match        <= '0;
            have_prev    <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                cnt       <= '0;
                locked    <= 1'b0;
                timeout   <= 1'b0;
                match     <= '0;
                have_prev <= 1'b0;
            end else begin
                case (state)
                    ARM: begin
                        if (rise) begin
                            cnt       <= CNT_W'(1);
                            match     <= '0;
                            have_prev <= 1'b0;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            cnt          <= CNT_W'(1);
                            timeout      <= 1'b0;
                            have_prev    <= 1'b1;
                            match        <= match_nxt;
                            locked       <= (match_nxt == MATCH_TOP);
                        end else if (cnt == MAX) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            match   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt       <= '0;
                        match     <= '0;
                        have_prev <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt;

    // the rise cycle itself is high, so a new window starts at 1 like cnt
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt      <= '0;
            high_time <= '0;
        end else if (!enable || state == IDLE) begin
            hcnt <= '0;
        end else if (state == ARM) begin
            hcnt <= rise ? CNT_W'(1) : '0;
        end else if (rise) begin
            high_time <= hcnt;
            hcnt      <= CNT_W'(1);
        end else if (s && hcnt != MAX) begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end
`else
    assign high_time = '0;
`endif

endmodule
